// File: rtl/lif_neuron_sync.sv
// +--------------------------------------------------------------------------+
// | lif_neuron_sync: clocked leaky integrate-and-fire neuron with N_IN       |
// | four-phase input channels and one four-phase spike output channel.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lif_neuron_sync #(
  parameter int N_IN        = 4,
  parameter int DATA_BITS   = 10,
  parameter int ACC_BITS    = 12,
  parameter int THOLD       = 512,
  parameter int LEAK        = 1,
  parameter int LEAK_PERIOD = 16,
  parameter int REFRACT     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN*DATA_BITS-1:0] data_in,
  input  logic [N_IN-1:0]           req_in,
  output logic [N_IN-1:0]           ack_in,
  output logic                      req_out,
  input  logic                      ack_out,
  output logic [ACC_BITS-1:0]       potential,
  output logic [1:0]                state_o
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int LC_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RC_W  = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int SUM_W = ACC_BITS + 2;

  typedef enum logic [1:0] {
    ST_INTEG    = 2'd0,
    ST_FIRE_REQ = 2'd1,
    ST_FIRE_REL = 2'd2,
    ST_REFRACT  = 2'd3
  } state_t;

  state_t               r_state;
  logic [N_IN-1:0]      r_req_meta;
  logic [N_IN-1:0]      r_sreq;
  logic                 r_ack_meta;
  logic                 r_sack;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [RC_W-1:0]      r_ref_cnt;

  logic [N_IN-1:0]      w_pend;
  logic                 w_grant_vld;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [DATA_BITS-1:0] w_weight;
  logic                 w_leak_tick;
  logic [SUM_W-1:0]     w_add;
  logic [SUM_W-1:0]     w_leak_amt;
  logic [SUM_W-1:0]     w_sum;
  logic [ACC_BITS-1:0]  w_clamped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_meta <= '0;
      r_sreq     <= '0;
      r_ack_meta <= 1'b0;
      r_sack     <= 1'b0;
    end else begin
      r_req_meta <= req_in;
      r_sreq     <= r_req_meta;
      r_ack_meta <= ack_out;
      r_sack     <= r_ack_meta;
    end
  end

  // A channel is pending only in IDLE, i.e. while its ack is still low.
  assign w_pend = r_sreq & ~ack_in;

  // Round-robin: search from r_rr_ptr upward, then wrap to the low channels.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_weight    = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (!w_grant_vld && w_pend[i] && (i >= int'(r_rr_ptr))) begin
        w_grant_vld = 1'b1;
        w_grant_idx = PTR_W'(i);
        w_weight    = data_in[i*DATA_BITS +: DATA_BITS];
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (!w_grant_vld && w_pend[i] && (i < int'(r_rr_ptr))) begin
        w_grant_vld = 1'b1;
        w_grant_idx = PTR_W'(i);
        w_weight    = data_in[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_in   <= '0;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (ack_in[i]) begin
          if (!r_sreq[i]) ack_in[i] <= 1'b0;
        end else if (w_grant_vld && (w_grant_idx == PTR_W'(i))) begin
          ack_in[i] <= 1'b1;
        end
      end
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == PTR_W'(N_IN - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  generate
    if (LEAK_PERIOD > 0) begin : g_leak_on
      logic [LC_W-1:0] r_leak_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_leak_cnt <= '0;
        end else if (r_leak_cnt == LC_W'(LEAK_PERIOD - 1)) begin
          r_leak_cnt <= '0;
        end else begin
          r_leak_cnt <= r_leak_cnt + 1'b1;
        end
      end
      assign w_leak_tick = (r_leak_cnt == LC_W'(LEAK_PERIOD - 1));
    end else begin : g_leak_off
      assign w_leak_tick = 1'b0;
    end
  endgenerate

  // Two guard bits: one for overflow above the accumulator, one for going negative.
  assign w_add      = w_grant_vld ? SUM_W'(w_weight) : '0;
  assign w_leak_amt = (w_leak_tick && (r_state == ST_INTEG)) ? SUM_W'(LEAK) : '0;
  assign w_sum      = SUM_W'(potential) + w_add - w_leak_amt;

  always_comb begin
    if (w_sum[SUM_W-1]) begin
      w_clamped = '0;
    end else if (w_sum[ACC_BITS]) begin
      w_clamped = '1;
    end else begin
      w_clamped = w_sum[ACC_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_INTEG;
      potential <= '0;
      req_out   <= 1'b0;
      r_ref_cnt <= '0;
    end else begin
      case (r_state)
        ST_INTEG: begin
          if (w_clamped >= ACC_BITS'(THOLD)) begin
            potential <= '0;
            req_out   <= 1'b1;
            r_state   <= ST_FIRE_REQ;
          end else begin
            potential <= w_clamped;
          end
        end
        ST_FIRE_REQ: begin
          if (r_sack) begin
            req_out <= 1'b0;
            r_state <= ST_FIRE_REL;
          end
        end
        ST_FIRE_REL: begin
          if (!r_sack) begin
            r_ref_cnt <= '0;
            r_state   <= (REFRACT == 0) ? ST_INTEG : ST_REFRACT;
          end
        end
        default: begin
          if (r_ref_cnt == RC_W'(REFRACT - 1)) begin
            r_state <= ST_INTEG;
          end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_sync.sv
// +--------------------------------------------------------------------------+
// | tb_lif_neuron_sync: self-checking bench for lif_neuron_sync.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lif_neuron_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] data_in;
  logic [3:0]  req_in;
  logic        ack_out;

  logic [3:0]  ack_a, ack_b, ack_c;
  logic        ro_a, ro_b, ro_c;
  logic [11:0] pot_a, pot_c;
  logic [9:0]  pot_b;
  logic [1:0]  st_a, st_b, st_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // a: leaky default neuron; b: narrow accumulator, max threshold; c: no leak
  lif_neuron_sync #(.N_IN(4), .DATA_BITS(10), .ACC_BITS(12), .THOLD(512),
    .LEAK(1), .LEAK_PERIOD(16), .REFRACT(4)) ua (
    .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .ack_in(ack_a),
    .req_out(ro_a), .ack_out(ack_out), .potential(pot_a), .state_o(st_a));

  lif_neuron_sync #(.N_IN(4), .DATA_BITS(10), .ACC_BITS(10), .THOLD(1023),
    .LEAK(1), .LEAK_PERIOD(0), .REFRACT(4)) ub (
    .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .ack_in(ack_b),
    .req_out(ro_b), .ack_out(ack_out), .potential(pot_b), .state_o(st_b));

  lif_neuron_sync #(.N_IN(4), .DATA_BITS(10), .ACC_BITS(12), .THOLD(512),
    .LEAK(1), .LEAK_PERIOD(0), .REFRACT(4)) uc (
    .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .ack_in(ack_c),
    .req_out(ro_c), .ack_out(ack_out), .potential(pot_c), .state_o(st_c));

  typedef struct {
    int ch;
    int w;
    int exp_pot;
    int exp_fire;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rq(input int sel);
    case (sel)
      0: return int'(ro_a);
      1: return int'(ro_b);
      default: return int'(ro_c);
    endcase
  endfunction

  function automatic int st(input int sel);
    case (sel)
      0: return int'(st_a);
      1: return int'(st_b);
      default: return int'(st_c);
    endcase
  endfunction

  task automatic reset_all();
    @(posedge clk); #1;
    rst = 1'b1; req_in = '0; ack_out = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic req_up(input int ch, input int w);
    @(posedge clk); #1;
    data_in[ch*10 +: 10] = 10'(w);
    req_in[ch] = 1'b1;
  endtask

  task automatic wait_ack(input int ch, input logic lvl, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack_c[ch] !== lvl && cyc < 30);
    if (ack_c[ch] !== lvl) chk("ack_timeout", int'(ack_c[ch]), int'(lvl));
  endtask

  task automatic send_hi(input int ch, input int w);
    int c;
    req_up(ch, w);
    wait_ack(ch, 1'b1, c);
  endtask

  task automatic send_lo(input int ch);
    int c;
    @(posedge clk); #1 req_in[ch] = 1'b0;
    wait_ack(ch, 1'b0, c);
  endtask

  task automatic send(input int ch, input int w);
    send_hi(ch, w);
    send_lo(ch);
  endtask

  task automatic wait_st(input int sel, input int val);
    int n;
    n = 0;
    while (st(sel) != val && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (st(sel) != val) chk("state_timeout", st(sel), val);
  endtask

  task automatic spike_ack(input int sel);
    int n;
    @(posedge clk); #1 ack_out = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rq(sel) != 0 && n < 40);
    if (rq(sel) != 0) chk("req_out_timeout", rq(sel), 0);
    @(posedge clk); #1 ack_out = 1'b0;
    wait_st(sel, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c, n, m, v0, prev, last_dec, ndec, fire, ch, w;
    int rise[4];

    tbl[0] = '{0,    0,   0, 0};
    tbl[1] = '{3,  511, 511, 0};
    tbl[2] = '{2,    0, 511, 0};
    tbl[3] = '{1,    1,   0, 1};
    tbl[4] = '{0,  512,   0, 1};
    tbl[5] = '{1,  100, 100, 0};
    tbl[6] = '{2,  411, 511, 0};
    tbl[7] = '{3, 1023,   0, 1};

    rst = 1'b1; req_in = '0; ack_out = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({ack_c, ro_c, pot_c, st_c}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_pot", int'(pot_c), 0);

    // Two weights of 300 with no leak: integrate, then fire on the second grant
    req_up(0, 300);
    wait_ack(0, 1'b1, c);
    chk("ack_latency", c, 4);
    send_lo(0);
    chk("first_weight", int'(pot_c), 300);
    send_hi(0, 300);
    chk("fire_req_out", int'(ro_c), 1);
    chk("fire_pot", int'(pot_c), 0);
    chk("fire_state", int'(st_c), 1);
    send_lo(0);
    @(posedge clk); #1 ack_out = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ro_c != 1'b0 && n < 40);
    chk("fire_rel_state", int'(st_c), 2);
    @(posedge clk); #1 ack_out = 1'b0;
    wait_st(2, 3);
    n = 0;
    while (st_c == 2'd3 && n < 20) begin @(negedge clk); n++; end
    chk("refract_len", n, 4);
    chk("after_refract_state", int'(st_c), 0);
    chk("after_refract_pot", int'(pot_c), 0);

    // All four channels at once: round-robin grants 0,1,2,3 on consecutive edges
    reset_all();
    for (int i = 0; i < 4; i++) rise[i] = -1;
    @(posedge clk); #1;
    data_in = {10'd40, 10'd30, 10'd20, 10'd10};
    req_in  = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (rise[i] < 0 && ack_c[i]) rise[i] = k;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_rise_ch%0d", i), rise[i], 4 + i);
    chk("ack_consistent", int'({ack_a, ack_b}), int'({ack_c, ack_c}));
    @(posedge clk); #1 req_in = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack_c != '0 && n < 30);
    chk("rr_ack_release", int'(ack_c), 0);
    chk("rr_sum", int'(pot_c), 100);

    // Leak: one weight of 5, then decrements of 1 spaced 16 cycles, down to 0
    reset_all();
    send(0, 5);
    v0 = int'(pot_a);
    chk("leak_start", int'(v0 == 5 || v0 == 4), 1);
    prev = v0; last_dec = -1; ndec = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (int'(pot_a) != prev) begin
        chk("leak_step", prev - int'(pot_a), 1);
        if (last_dec >= 0) chk("leak_gap", k - last_dec, 16);
        last_dec = k;
        ndec++;
        prev = int'(pot_a);
      end
    end
    chk("leak_count", ndec, v0);
    chk("leak_floor", int'(pot_a), 0);
    chk("leak_quiet", int'({ro_a, st_a}), 0);

    // Weight arriving in refractory is acknowledged but discarded
    reset_all();
    send(0, 300);
    send_hi(1, 300);
    send_lo(1);
    @(posedge clk); #1 ack_out = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ro_c != 1'b0 && n < 40);
    @(posedge clk); #1 ack_out = 1'b0;
    wait_st(2, 3);
    send_hi(2, 200);
    chk("refract_pot", int'(pot_c), 0);
    send_lo(2);
    wait_st(2, 0);
    chk("refract_discard", int'(pot_c), 0);
    send(2, 200);
    chk("post_refract_integ", int'(pot_c), 200);

    // Narrow accumulator: 1000 + 100 clamps to 1023, which meets threshold
    reset_all();
    send(0, 1000);
    chk("clamp_pre", int'(pot_b), 1000);
    send_hi(1, 100);
    chk("clamp_fire", int'(ro_b), 1);
    chk("clamp_pot", int'(pot_b), 0);
    chk("clamp_state", int'(st_b), 1);
    send_lo(1);
    spike_ack(1);

    // Asynchronous reset in FIRE_REQ with channel 1 mid-handshake
    reset_all();
    send(0, 300);
    send_hi(1, 300);
    chk("pre_rst_state", int'(st_c), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({ack_c, ro_c, pot_c, st_c}), 0);
    req_in = '0;
    @(posedge clk); #1 rst = 1'b0;
    send(1, 77);
    chk("post_rst_ch1", int'(pot_c), 77);

    // Table-driven vectors on the leak-free neuron
    reset_all();
    for (int i = 0; i < 8; i++) begin
      send_hi(tbl[i].ch, tbl[i].w);
      chk($sformatf("tbl%0d_pot", i), int'(pot_c), tbl[i].exp_pot);
      chk($sformatf("tbl%0d_fire", i), int'(ro_c), tbl[i].exp_fire);
      send_lo(tbl[i].ch);
      if (tbl[i].exp_fire != 0) spike_ack(2);
    end

    // Random weights against a running-sum model with fire-and-reset
    reset_all();
    m = 0;
    for (int it = 0; it < 40; it++) begin
      ch = int'($urandom_range(0, 3));
      w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 400));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_hi(ch, w);
      fire = (m + w >= 512) ? 1 : 0;
      m = (fire != 0) ? 0 : m + w;
      chk($sformatf("rnd%0d_pot", it), int'(pot_c), m);
      chk($sformatf("rnd%0d_fire", it), int'(ro_c), fire);
      send_lo(ch);
      if (fire != 0) spike_ack(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
